// File: rtl/wasm_pkg.sv
// Shared types for the wasm *.const emitter: constant type codes, opcodes, FSM states.
package wasm_pkg;

    typedef enum logic [1:0] {
        TYPE_I32 = 2'd0,
        TYPE_I64 = 2'd1,
        TYPE_F32 = 2'd2,
        TYPE_F64 = 2'd3
    } const_type_e;

    localparam logic [7:0] OP_I32_CONST = 8'h41;
    localparam logic [7:0] OP_I64_CONST = 8'h42;
    localparam logic [7:0] OP_F32_CONST = 8'h43;
    localparam logic [7:0] OP_F64_CONST = 8'h44;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPCODE  = 2'd1,
        ST_PAYLOAD = 2'd2
    } emit_state_e;

    function automatic logic [7:0] opcode_of(const_type_e t);
        case (t)
            TYPE_I32: return OP_I32_CONST;
            TYPE_I64: return OP_I64_CONST;
            TYPE_F32: return OP_F32_CONST;
            default:  return OP_F64_CONST;
        endcase
    endfunction

endpackage

// File: rtl/wasm_const_emitter_if.sv
// Request/byte-stream bundle of the const emitter; slave is the emitter side.
interface wasm_const_emitter_if;
    import wasm_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_type;
    logic [63:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;

    modport master (
        output in_valid, in_type, in_value, out_ready,
        input  in_ready, out_valid, out_byte, out_last
    );

    modport slave (
        input  in_valid, in_type, in_value, out_ready,
        output in_ready, out_valid, out_byte, out_last
    );

endinterface

// File: rtl/sleb128_step.sv
// One sLEB128 output group from the shift register. CONST_EMITTER_PAD_LEB_EN selects
// fixed-width padding (5/10 bytes) with the continuation bit taken from the byte count.
module sleb128_step (
    input  logic [63:0] shreg_i,
    input  logic        is_i64_i,
    input  logic [3:0]  cnt_i,
    output logic [7:0]  byte_o,
    output logic        more_o,
    output logic [63:0] rest_o
);
    logic [6:0] grp;

    assign grp    = shreg_i[6:0];
    // Arithmetic shift keeps the sign fill going, which padding relies on too.
    assign rest_o = $signed(shreg_i) >>> 7;

`ifdef CONST_EMITTER_PAD_LEB_EN
    assign more_o = (cnt_i != (is_i64_i ? 4'd9 : 4'd4));
`else
    logic unused_pad;
    assign unused_pad = ^{cnt_i, is_i64_i};
    assign more_o = !(((rest_o == '0) && !grp[6]) || ((rest_o == '1) && grp[6]));
`endif

    assign byte_o = {more_o, grp};

endmodule

// File: rtl/wasm_const_emitter.sv
// Serialises a typed constant into wasm i32/i64/f32/f64.const bytecode, one byte per beat.
// Optional macro CONST_EMITTER_PAD_LEB_EN pads integer payloads to 5/10 bytes.
module wasm_const_emitter
    import wasm_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    wasm_const_emitter_if.slave  bus,
    output logic                 busy
);
    emit_state_e state_q, state_d;
    const_type_e type_q, type_d;
    logic [63:0] shreg_q, shreg_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        in_ready_c, out_valid_c, out_last_c;
    logic [7:0]  out_byte_c;
    logic        is_float;
    logic [3:0]  float_last;
    logic [7:0]  leb_byte;
    logic        leb_more;
    logic [63:0] leb_rest;

    assign is_float   = type_q[1];
    assign float_last = (type_q == TYPE_F64) ? 4'd7 : 4'd3;

    sleb128_step u_step (
        .shreg_i  (shreg_q),
        .is_i64_i (type_q == TYPE_I64),
        .cnt_i    (cnt_q),
        .byte_o   (leb_byte),
        .more_o   (leb_more),
        .rest_o   (leb_rest)
    );

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_byte_c  = 8'h00;
        out_last_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    type_d  = const_type_e'(bus.in_type);
                    cnt_d   = '0;
                    state_d = ST_OPCODE;
                    case (const_type_e'(bus.in_type))
                        TYPE_I32: shreg_d = {{32{bus.in_value[31]}}, bus.in_value[31:0]};
                        TYPE_F32: shreg_d = {32'h0, bus.in_value[31:0]};
                        default:  shreg_d = bus.in_value;
                    endcase
                end
            end
            ST_OPCODE: begin
                out_valid_c = 1'b1;
                out_byte_c  = opcode_of(type_q);
                if (bus.out_ready) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                out_valid_c = 1'b1;
                if (is_float) begin
                    out_byte_c = shreg_q[7:0];
                    out_last_c = (cnt_q == float_last);
                end else begin
                    out_byte_c = leb_byte;
                    out_last_c = !leb_more;
                end
                if (bus.out_ready) begin
                    shreg_d = is_float ? (shreg_q >> 8) : leb_rest;
                    cnt_d   = cnt_q + 4'd1;
                    if (out_last_c) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            type_q  <= TYPE_I32;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_byte  = out_byte_c;
    assign bus.out_last  = out_last_c;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wasm_const_emitter.sv
// Randomised check of wasm_const_emitter against a byte-list model of the wasm encodings.
module tb_wasm_const_emitter;
    import wasm_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;

    wasm_const_emitter_if bus ();

    wasm_const_emitter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoding straight from the wasm rules, as a list of bytes.
    task automatic build_exp(input logic [1:0] t, input logic [63:0] v);
        longint s;
        int     x;
        logic [7:0] b;
        bit     more;
        exp_q.delete();
        exp_q.push_back(8'h41 + {6'd0, t});
        if (t == TYPE_F32) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
        end else if (t == TYPE_F64) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(v[8*i +: 8]);
        end else begin
            x = v[31:0];
            s = (t == TYPE_I32) ? longint'(x) : longint'(v);
`ifdef CONST_EMITTER_PAD_LEB_EN
            for (int i = 0; i < ((t == TYPE_I32) ? 5 : 10); i++) begin
                b = s[7:0];
                s = s >>> 7;
                b[7] = (i != ((t == TYPE_I32) ? 4 : 9));
                exp_q.push_back(b);
            end
`else
            do begin
                b = s[7:0];
                s = s >>> 7;
                more = !((s == 0 && !b[6]) || (s == -1 && b[6]));
                b[7] = more;
                exp_q.push_back(b);
            end while (more);
`endif
        end
    endtask

    // mode 0: ready always high; 1: ready 1,0,0 repeating; 2: random ready.
    // abort_at >= 0 pulls reset while that byte index is on the bus.
    task automatic run_frame(input logic [1:0] t, input logic [63:0] v, input int mode,
                             input int abort_at);
        int idx = 0;
        int cyc = 0;
        int pat = 0;
        logic rdy;
        logic lst;
        build_exp(t, v);
        check("idle", {61'd0, bus.in_ready, bus.out_valid, busy}, 64'b100);
        bus.in_valid  = 1'b1;
        bus.in_type   = t;
        bus.in_value  = v;
        bus.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        while (idx < exp_q.size()) begin
            if (cyc++ > 200) begin
                check("timeout", 64'd0, 64'd1);
                break;
            end
            if (idx == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort", {52'd0, bus.out_valid, bus.in_ready, busy, bus.out_last, bus.out_byte},
                      {52'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
                @(negedge clk);
                bus.in_valid = 1'b0;
                reset = 1'b1;
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((pat % 3) == 0);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            bus.out_ready = rdy;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_type   = 2'($urandom);
            bus.in_value  = {$urandom, $urandom};
            lst = (idx == exp_q.size() - 1);
            check($sformatf("byte%0d", idx),
                  {52'd0, bus.out_valid, bus.in_ready, busy, bus.out_last, bus.out_byte},
                  {52'd0, 1'b1, 1'b0, 1'b1, lst, exp_q[idx]});
            @(posedge clk);
            if (rdy) idx++;
            pat++;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'($urandom_range(0, 1));
        check("gap", {61'd0, bus.in_ready, bus.out_valid, busy}, 64'b100);
    endtask

    logic [63:0] bnd[8] = '{64'd0, 64'hffff_ffff_ffff_ffff, 64'd63, 64'd64,
                            64'hffff_ffff_ffff_ffc0, 64'hffff_ffff_ffff_ffbf,
                            64'h7fff_ffff_ffff_ffff, 64'h8000_0000_0000_0000};

    initial begin
        logic [63:0] v;
        int sel;
        bus.in_valid  = 1'b0;
        bus.in_type   = 2'd0;
        bus.in_value  = 64'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", {52'd0, bus.in_ready, bus.out_valid, busy, bus.out_last, bus.out_byte},
              {52'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        reset = 1'b1;
        @(negedge clk);

        run_frame(TYPE_F32, 64'h0000_0000_c000_0000, 0, -1);
        run_frame(TYPE_I32, 64'h0000_0000_ffff_ffff, 0, -1);
        run_frame(TYPE_I32, 64'd64, 0, -1);
        run_frame(TYPE_I32, 64'd624485, 0, -1);
        run_frame(TYPE_I64, 64'hffff_ffff_fffe_1dc0, 0, -1);
        run_frame(TYPE_F64, 64'h3ff0_0000_0000_0000, 0, -1);
        run_frame(TYPE_F32, 64'h0000_0000_c000_0000, 1, -1);
        run_frame(TYPE_F64, 64'h3ff0_0000_0000_0000, 0, 2);
        run_frame(TYPE_I32, 64'h0000_0000_ffff_ffff, 0, -1);
        run_frame(TYPE_I64, 64'd0, 0, -1);
        run_frame(TYPE_I32, 64'h1234_5678_ffff_ffff, 2, -1);
        run_frame(TYPE_I64, 64'h8000_0000_0000_0000, 1, -1);

        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 2);
            case (sel)
                0:       v = {$urandom, $urandom};
                1:       v = 64'(longint'(int'($urandom_range(0, 511)) - 256));
                default: v = bnd[$urandom_range(0, 7)];
            endcase
            run_frame(2'($urandom), v, $urandom_range(0, 2), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
